// File: rtl/blit_pkg.sv
// Shared types and constants for the rectangle blitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package blit_pkg;

  // Blitter control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Command modes
  localparam logic MODE_FILL  = 1'b0;
  localparam logic MODE_CLEAR = 1'b1;

  // Default VGA plot-path geometry and clear colour
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_BG_COLOR = 0;

endpackage

// File: rtl/rect_blitter_if.sv
// Command + pixel-stream bundle between a command source and the blitter.
// Latency: n/a (wires only).
// Backpressure: pause from the frame-buffer arbiter stalls the pixel stream.
interface rect_blitter_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int DIM_W   = 8,
  parameter int COLOR_W = 3
) ();

  logic               start;
  logic               mode;
  logic [X_W-1:0]     x_in;
  logic [Y_W-1:0]     y_in;
  logic [DIM_W-1:0]   width;
  logic [DIM_W-1:0]   height;
  logic [COLOR_W-1:0] c_in;
  logic               pause;
`ifdef RECT_BLITTER_OUTLINE_EN
  logic               outline;
`endif
  logic               busy;
  logic               plot;
  logic [X_W-1:0]     x_out;
  logic [Y_W-1:0]     y_out;
  logic [COLOR_W-1:0] c_out;
  logic               done;

  // Command source / frame-buffer side
  modport master (
    output start, mode, x_in, y_in, width, height, c_in, pause,
`ifdef RECT_BLITTER_OUTLINE_EN
    output outline,
`endif
    input  busy, plot, x_out, y_out, c_out, done
  );

  // Blitter side
  modport slave (
    input  start, mode, x_in, y_in, width, height, c_in, pause,
`ifdef RECT_BLITTER_OUTLINE_EN
    input  outline,
`endif
    output busy, plot, x_out, y_out, c_out, done
  );

endinterface

// File: rtl/raster_counter.sv
// Row-major cx/cy pixel counter with wrap at w-1 / h-1 (optional border flag).
// Latency: counters update on the edge where en is high; flags are combinational.
// Backpressure: en low holds the position (caller drops en while stalled).
module raster_counter #(
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [DIM_W-1:0] w,
  input  logic [DIM_W-1:0] h,
`ifdef RECT_BLITTER_OUTLINE_EN
  input  logic             right_edge,
  input  logic             bottom_edge,
  output logic             on_border,
`endif
  output logic             row_end,
  output logic             last_pixel
);

  logic [DIM_W-1:0] cx;
  logic [DIM_W-1:0] cy;
  logic [DIM_W-1:0] w_last;
  logic [DIM_W-1:0] h_last;

  assign w_last     = w - DIM_W'(1);
  assign h_last     = h - DIM_W'(1);
  assign row_end    = (cx == w_last);
  assign last_pixel = row_end && (cy == h_last);

`ifdef RECT_BLITTER_OUTLINE_EN
  // Right/bottom columns only count when they are real rectangle edges, not clip lines
  assign on_border = (cx == '0) || (cy == '0) ||
                     (row_end && right_edge) || ((cy == h_last) && bottom_edge);
`endif

  // Advance left-to-right, then wrap to the next row
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx <= '0;
      cy <= '0;
    end else if (load) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (row_end) begin
        cx <= '0;
        cy <= cy + DIM_W'(1);
      end else begin
        cx <= cx + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/rect_blitter.sv
// Rectangle fill / screen clear rasteriser, one clipped pixel per cycle into the frame buffer.
// Latency: first plot one cycle after start is sampled, done one cycle after the last pixel.
// Backpressure: pause holds position and suppresses plot; start is ignored while busy.
// Optional: define RECT_BLITTER_OUTLINE_EN to add the outline (border-only) input.
module rect_blitter
  import blit_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int DIM_W    = 8,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int BG_COLOR = DEF_BG_COLOR
) (
  input  logic          clk,
  input  logic          reset,
  rect_blitter_if.slave bus
);

  // One extra bit so SCREEN - origin and the min() never wrap
  localparam int CW = DIM_W + 1;

  state_t             state;
  logic               live;
  logic               done_q;
  logic [X_W-1:0]     x0;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [COLOR_W-1:0] c_q;
  logic [DIM_W-1:0]   w_q;
  logic [DIM_W-1:0]   h_q;
  logic               row_end;
  logic               last_pixel;

  logic [CW-1:0]      room_x;
  logic [CW-1:0]      room_y;
  logic [CW-1:0]      req_w;
  logic [CW-1:0]      req_h;
  logic [CW-1:0]      clip_w;
  logic [CW-1:0]      clip_h;
  logic [X_W-1:0]     org_x;
  logic [Y_W-1:0]     org_y;
  logic [DIM_W-1:0]   eff_w;
  logic [DIM_W-1:0]   eff_h;
  logic [COLOR_W-1:0] cmd_c;
  logic               degenerate;
  logic               accept;

`ifdef RECT_BLITTER_OUTLINE_EN
  logic               outline_q;
  logic               right_edge_q;
  logic               bottom_edge_q;
  logic               on_border;
`endif

  assign accept = (state == IDLE) && bus.start;

  // Command decode and clipping of the requested rectangle to the screen
  always_comb begin
    room_x = CW'(SCREEN_W) - CW'(bus.x_in);
    room_y = CW'(SCREEN_H) - CW'(bus.y_in);
    req_w  = CW'(bus.width);
    req_h  = CW'(bus.height);
    clip_w = (req_w < room_x) ? req_w : room_x;
    clip_h = (req_h < room_y) ? req_h : room_y;
    if (bus.mode == MODE_CLEAR) begin
      org_x      = '0;
      org_y      = '0;
      eff_w      = DIM_W'(SCREEN_W);
      eff_h      = DIM_W'(SCREEN_H);
      cmd_c      = COLOR_W'(BG_COLOR);
      degenerate = 1'b0;
    end else begin
      org_x      = bus.x_in;
      org_y      = bus.y_in;
      eff_w      = DIM_W'(clip_w);
      eff_h      = DIM_W'(clip_h);
      cmd_c      = bus.c_in;
      degenerate = (32'(bus.x_in) >= 32'(SCREEN_W)) ||
                   (32'(bus.y_in) >= 32'(SCREEN_H)) ||
                   (clip_w == '0) || (clip_h == '0);
    end
  end

  raster_counter #(
    .DIM_W (DIM_W)
  ) u_counter (
    .clk         (clk),
    .reset       (reset),
    .load        (accept),
    .en          ((state == RUN) && live && !last_pixel),
    .w           (w_q),
    .h           (h_q),
`ifdef RECT_BLITTER_OUTLINE_EN
    .right_edge  (right_edge_q),
    .bottom_edge (bottom_edge_q),
    .on_border   (on_border),
`endif
    .row_end     (row_end),
    .last_pixel  (last_pixel)
  );

  // Control FSM; live marks that the pixel on x_q/y_q is issued this cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      live   <= 1'b0;
      done_q <= 1'b0;
      x0     <= '0;
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= '0;
      w_q    <= '0;
      h_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          live   <= 1'b0;
          if (bus.start) begin
            x0  <= org_x;
            w_q <= eff_w;
            h_q <= eff_h;
            if (degenerate) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= RUN;
              live  <= !bus.pause;
              x_q   <= org_x;
              y_q   <= org_y;
              c_q   <= cmd_c;
            end
          end
        end
        RUN: begin
          if (live && last_pixel) begin
            state  <= DONE;
            live   <= 1'b0;
            done_q <= 1'b1;
          end else begin
            live <= !bus.pause;
            if (live) begin
              if (row_end) begin
                x_q <= x0;
                y_q <= y_q + Y_W'(1);
              end else begin
                x_q <= x_q + X_W'(1);
              end
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          live   <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef RECT_BLITTER_OUTLINE_EN
  // Outline flag and which far edges are genuine (unclipped) borders
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outline_q     <= 1'b0;
      right_edge_q  <= 1'b0;
      bottom_edge_q <= 1'b0;
    end else if (accept) begin
      outline_q     <= (bus.mode == MODE_FILL) && bus.outline;
      right_edge_q  <= !((bus.mode == MODE_FILL) && (req_w > room_x));
      bottom_edge_q <= !((bus.mode == MODE_FILL) && (req_h > room_y));
    end
  end

  assign bus.plot = live && (!outline_q || on_border);
`else
  assign bus.plot = live;
`endif

  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.x_out = x_q;
  assign bus.y_out = y_q;
  assign bus.c_out = c_q;

endmodule

// File: tb/tb_rect_blitter.sv
// Self-checking bench for rect_blitter: scoreboard of expected pixels plus timing checks.
// Latency: n/a.
// Backpressure: exercises pause and start-while-busy.
module tb_rect_blitter;
  import blit_pkg::*;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int DIM_W = 8;
  localparam int COLOR_W = 3;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] c;
  } pix_t;

  logic clk;
  logic reset;
  pix_t exp_q[$];
  pix_t mon_e;
  int   checks, fails, cyc, start_cyc, plot_cnt, done_cnt, done_rel;
  logic [3+X_W+Y_W+COLOR_W-1:0] obs;

  rect_blitter_if #(.X_W(X_W), .Y_W(Y_W), .DIM_W(DIM_W), .COLOR_W(COLOR_W)) bif ();

  rect_blitter #(
    .X_W(X_W), .Y_W(Y_W), .DIM_W(DIM_W), .COLOR_W(COLOR_W),
    .SCREEN_W(DEF_SCREEN_W), .SCREEN_H(DEF_SCREEN_H), .BG_COLOR(DEF_BG_COLOR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every plot must match the next expected pixel
  always @(negedge clk) begin
    if (reset === 1'b1 && bif.plot === 1'b1) begin
      plot_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_plot: got (%0d,%0d) c=%0d, required no plot", bif.x_out, bif.y_out, bif.c_out);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bif.x_out, bif.y_out, bif.c_out} !== {mon_e.x, mon_e.y, mon_e.c}) begin
          fails++;
          $display("FAIL pixel: got (%0d,%0d) c=%0d, required (%0d,%0d) c=%0d",
                   bif.x_out, bif.y_out, bif.c_out, mon_e.x, mon_e.y, mon_e.c);
        end
      end
    end
    if (bif.done === 1'b1) begin
      done_cnt++;
      done_rel = cyc - start_cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_rect(input int x, input int y, input int w, input int h, input int c, input bit outl);
    pix_t p;
    for (int yy = y; yy < y + h && yy < DEF_SCREEN_H; yy++)
      for (int xx = x; xx < x + w && xx < DEF_SCREEN_W; xx++)
        if (!outl || xx == x || yy == y || xx == x + w - 1 || yy == y + h - 1) begin
          p.x = X_W'(xx);
          p.y = Y_W'(yy);
          p.c = COLOR_W'(c);
          exp_q.push_back(p);
        end
  endtask

  task automatic issue(input logic m, input int x, input int y, input int w, input int h, input int c);
    bif.mode   = m;
    bif.x_in   = X_W'(x);
    bif.y_in   = Y_W'(y);
    bif.width  = DIM_W'(w);
    bif.height = DIM_W'(h);
    bif.c_in   = COLOR_W'(c);
    bif.start  = 1'b1;
    start_cyc  = cyc;
    done_cnt   = 0;
    plot_cnt   = 0;
    tick();
    bif.start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    ok = (done_cnt != 0);
  endtask

  task automatic test_reset();
    tick();
    tick();
    obs = {bif.plot, bif.done, bif.busy, bif.x_out, bif.y_out, bif.c_out};
    checks++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, required 0", obs);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fill_basic();
    bit ok;
    push_rect(10, 20, 3, 2, 5, 1'b0);
    issue(MODE_FILL, 10, 20, 3, 2, 5);
    wait_done(50, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL fill_timeout: got no done, required done"); end
    checks++;
    if (done_rel != 7) begin fails++; $display("FAIL fill_done_cycle: got %0d, required 7", done_rel); end
    checks++;
    if (bif.busy !== 1'b1) begin fails++; $display("FAIL fill_busy_in_done: got %b, required 1", bif.busy); end
    tick();
    checks++;
    if ({bif.busy, bif.done} !== 2'b00) begin
      fails++; $display("FAIL fill_after_done: got busy/done %b, required 00", {bif.busy, bif.done});
    end
    checks++;
    if (plot_cnt != 6 || exp_q.size() != 0) begin
      fails++; $display("FAIL fill_count: got %0d plots (%0d left), required 6 (0 left)", plot_cnt, exp_q.size());
    end
  endtask

  task automatic test_clear();
    bit ok;
    push_rect(0, 0, DEF_SCREEN_W, DEF_SCREEN_H, DEF_BG_COLOR, 1'b0);
    issue(MODE_CLEAR, 77, 33, 5, 5, 6);
    wait_done(20000, ok);
    checks++;
    if (!ok || done_rel != 19201) begin
      fails++; $display("FAIL clear_done: got ok=%0d cycle %0d, required cycle 19201", ok, done_rel);
    end
    checks++;
    if (plot_cnt != 19200 || exp_q.size() != 0) begin
      fails++; $display("FAIL clear_count: got %0d plots (%0d left), required 19200", plot_cnt, exp_q.size());
    end
    tick();
  endtask

  task automatic test_clip();
    bit ok;
    push_rect(158, 118, 5, 5, 3, 1'b0);
    issue(MODE_FILL, 158, 118, 5, 5, 3);
    wait_done(50, ok);
    checks++;
    if (!ok || done_rel != 5) begin
      fails++; $display("FAIL clip_done: got ok=%0d cycle %0d, required cycle 5", ok, done_rel);
    end
    checks++;
    if (plot_cnt != 4 || exp_q.size() != 0) begin
      fails++; $display("FAIL clip_count: got %0d plots, required 4", plot_cnt);
    end
    tick();
  endtask

  task automatic test_degenerate();
    int cases[4][4] = '{'{10, 10, 0, 4}, '{160, 10, 3, 3}, '{10, 10, 4, 0}, '{5, 120, 2, 2}};
    bit ok;
    for (int i = 0; i < 4; i++) begin
      issue(MODE_FILL, cases[i][0], cases[i][1], cases[i][2], cases[i][3], 7);
      wait_done(10, ok);
      checks++;
      if (!ok || done_rel != 1 || plot_cnt != 0) begin
        fails++;
        $display("FAIL degenerate_%0d: got ok=%0d done cycle %0d plots %0d, required cycle 1 plots 0",
                 i, ok, done_rel, plot_cnt);
      end
      tick();
    end
  endtask

  task automatic test_pause();
    int n = 0;
    int rel;
    push_rect(30, 40, 4, 1, 2, 1'b0);
    issue(MODE_FILL, 30, 40, 4, 1, 2);
    while (done_cnt == 0 && n < 50) begin
      rel = cyc - start_cyc;
      if (rel == 2) bif.pause = 1'b1;
      if (rel == 5) bif.pause = 1'b0;
      tick();
      n++;
    end
    bif.pause = 1'b0;
    checks++;
    if (done_cnt == 0 || done_rel != 8) begin
      fails++; $display("FAIL pause_done: got cycle %0d (done=%0d), required cycle 8", done_rel, done_cnt);
    end
    checks++;
    if (plot_cnt != 4 || exp_q.size() != 0) begin
      fails++; $display("FAIL pause_count: got %0d plots, required 4", plot_cnt);
    end
    tick();
  endtask

  task automatic test_restart_ignored();
    int n = 0;
    int rel;
    push_rect(50, 60, 3, 3, 4, 1'b0);
    issue(MODE_FILL, 50, 60, 3, 3, 4);
    while (done_cnt == 0 && n < 50) begin
      rel = cyc - start_cyc;
      if (rel == 3) begin
        bif.x_in = '0; bif.y_in = '0; bif.width = 8'd5; bif.height = 8'd5; bif.start = 1'b1;
      end
      if (rel == 4) bif.start = 1'b0;
      tick();
      n++;
    end
    checks++;
    if (done_cnt == 0 || done_rel != 10) begin
      fails++; $display("FAIL restart_done: got cycle %0d, required cycle 10", done_rel);
    end
    tick();
    tick();
    checks++;
    if (done_cnt != 1 || plot_cnt != 9 || exp_q.size() != 0) begin
      fails++; $display("FAIL restart_count: got %0d dones %0d plots, required 1 done 9 plots", done_cnt, plot_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    push_rect(0, 0, 2, 2, 1, 1'b0);
    issue(MODE_FILL, 0, 0, 2, 2, 1);
    wait_done(50, ok);
    checks++;
    if (!ok || done_rel != 5 || plot_cnt != 4) begin
      fails++; $display("FAIL b2b_first: got cycle %0d plots %0d, required cycle 5 plots 4", done_rel, plot_cnt);
    end
    tick();
    push_rect(70, 100, 3, 1, 7, 1'b0);
    issue(MODE_FILL, 70, 100, 3, 1, 7);
    wait_done(50, ok);
    checks++;
    if (!ok || done_rel != 4 || plot_cnt != 3 || exp_q.size() != 0) begin
      fails++; $display("FAIL b2b_second: got cycle %0d plots %0d, required cycle 4 plots 3", done_rel, plot_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int pc;
    push_rect(20, 20, 10, 10, 6, 1'b0);
    issue(MODE_FILL, 20, 20, 10, 10, 6);
    while (cyc - start_cyc < 5) tick();
    reset = 1'b0;
    #1;
    obs = {bif.plot, bif.done, bif.busy, bif.x_out, bif.y_out, bif.c_out};
    checks++;
    if (obs !== '0) begin
      fails++; $display("FAIL midrun_reset_outputs: got %h, required 0", obs);
    end
    exp_q.delete();
    tick();
    tick();
    pc = plot_cnt;
    done_cnt = 0;
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (plot_cnt != pc || done_cnt != 0) begin
      fails++; $display("FAIL midrun_aftermath: got %0d extra plots %0d dones, required 0 and 0", plot_cnt - pc, done_cnt);
    end
  endtask

`ifdef RECT_BLITTER_OUTLINE_EN
  task automatic test_outline();
    bit ok;
    push_rect(40, 50, 4, 3, 1, 1'b1);
    bif.outline = 1'b1;
    issue(MODE_FILL, 40, 50, 4, 3, 1);
    bif.outline = 1'b0;
    wait_done(50, ok);
    checks++;
    if (!ok || done_rel != 13) begin
      fails++; $display("FAIL outline_done: got cycle %0d, required cycle 13", done_rel);
    end
    checks++;
    if (plot_cnt != 10 || exp_q.size() != 0) begin
      fails++; $display("FAIL outline_count: got %0d plots, required 10", plot_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    reset = 1'b0;
    bif.start = 1'b0;
    bif.mode = MODE_FILL;
    bif.x_in = '0;
    bif.y_in = '0;
    bif.width = '0;
    bif.height = '0;
    bif.c_in = '0;
    bif.pause = 1'b0;
`ifdef RECT_BLITTER_OUTLINE_EN
    bif.outline = 1'b0;
`endif
    test_reset();
    test_fill_basic();
    test_clear();
    test_clip();
    test_degenerate();
    test_pause();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid_run();
`ifdef RECT_BLITTER_OUTLINE_EN
    test_outline();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rect_blitter.md
Name: rect_blitter

Overview:
- Parameterised rectangle rasteriser for the pixel-plot VGA path. Emits one pixel per cycle (x, y, colour, plot strobe) into the frame-buffer write port.
- Accepts a start/done command handshake and supports two modes: fill a rectangle, or clear the whole screen.
- Adds clipping to screen bounds, a stall input for write-port arbitration, and a one-cycle done pulse.
- Replaces separate per-purpose draw and erase engines with one engine.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- DIM_W, 8, width/height operand width
- COLOR_W, 3, colour width
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows
- BG_COLOR, 0, colour used by clear mode

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  command request; sampled only in IDLE
- mode  in  1  0 = fill rectangle, 1 = clear screen
- x_in  in  X_W  rectangle origin x
- y_in  in  Y_W  rectangle origin y
- width  in  DIM_W  rectangle width in pixels
- height  in  DIM_W  rectangle height in pixels
- c_in  in  COLOR_W  fill colour
- pause  in  1  stall; freezes traversal while high
- busy  out  1  high in RUN and DONE
- plot  out  1  pixel write strobe
- x_out  out  X_W  pixel x
- y_out  out  Y_W  pixel y
- c_out  out  COLOR_W  pixel colour
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all counters and origin/size/colour registers cleared; plot=0, done=0, busy=0; x_out=0, y_out=0, c_out=0.
- States: IDLE -> RUN -> DONE -> IDLE. Skip path: IDLE -> DONE.
- IDLE, start=1: latch the command.
  - mode=0: origin (x_in, y_in), colour c_in.
  - mode=1: origin (0, 0), size SCREEN_W x SCREEN_H, colour BG_COLOR. x_in, y_in, width, height and c_in are ignored.
- Clipping at latch:
  - effective width = min(width, SCREEN_W - x_in).
  - effective height = min(height, SCREEN_H - y_in).
  - Compute at DIM_W+1 bits; no wrap-around.
- Degenerate command: if effective width = 0, effective height = 0, x_in >= SCREEN_W or y_in >= SCREEN_H, go straight to DONE. No pixel is plotted.
- RUN:
  - plot = !pause; x_out = x0 + cx; y_out = y0 + cy; c_out = latched colour.
  - When pause=0, advance the counters: cx increments; at cx = w-1, cx wraps to 0 and cy increments.
  - After plotting the pixel at cx = w-1, cy = h-1, go to DONE.
  - When pause=1, counters and outputs hold and plot=0.
- Traversal order is row-major: left to right, then top to bottom.
- DONE: done=1 for exactly one cycle, plot=0, then IDLE.
- Latency with pause held low:
  - start sampled at edge 0.
  - First plot is visible in cycle 1.
  - Last plot is in cycle w*h.
  - done is high in cycle w*h+1.
- start while busy is ignored; no queueing.
- Reset asserted mid-RUN aborts immediately. No done pulse is produced and no further plot occurs.
- Outputs are registered (x_out, y_out, c_out, plot, done); no combinational path from inputs to outputs.
- x_out/y_out never exceed SCREEN_W-1 / SCREEN_H-1.

Optional Feature:
- Macro: RECT_BLITTER_OUTLINE_EN.
- Defined:
  - Extra input port `outline` (1 bit), latched at start; ignored in clear mode.
  - When outline=1, plot is asserted only when cx = 0, cx = w-1, cy = 0 or cy = h-1.
  - Traversal timing and done timing are unchanged, still w*h cycles.
  - Clipped edges do not count as border.
- Undefined: port absent; behaviour identical to outline=0.

Decomposition:
- Package blit_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Mode constants MODE_FILL = 0, MODE_CLEAR = 1.
  - Default SCREEN_W / SCREEN_H / BG_COLOR constants.
- One sub-module, raster_counter:
  - DIM_W-wide cx/cy counter pair with enable, load, and wrap at w-1/h-1.
  - Outputs last_pixel and, under the macro, on_border.
- Clipping arithmetic and the FSM stay in rect_blitter.

Test Plan:
- Fill x=10, y=20, w=3, h=2, c=5, pause=0 -> six plots in order (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), all c_out=5. done pulses in cycle 7; busy falls in cycle 8.
- Clear mode -> 19200 plots covering (0,0) to (159,119), all c_out=0, then a single done pulse.
- Clipping: x=158, y=118, w=5, h=5 -> only (158,118), (159,118), (158,119), (159,119) plotted. Degenerate cases w=0 and x=160 -> no plot; done one cycle after start.
- Pause: w=4, h=1, pause high for cycles 2-4 -> plots (x0, x0+1) before the pause, (x0+2, x0+3) after. No duplicate or skipped pixel; done delayed by 3 cycles.
- Robustness:
  - reset pulsed low mid-RUN -> outputs are at their reset values within the same cycle; no done pulse.
  - start re-asserted during RUN -> ignored; pixel count unchanged.
- With RECT_BLITTER_OUTLINE_EN: w=4, h=3, outline=1 -> 10 plots; interior (1,1) and (2,1) not plotted; done at cycle 13.
